// File: rtl/booth_mult_r4_pkg.sv
// booth_mult_r4_pkg: shared states, digit-select encodings and iteration count for the radix-4 Booth multiplier
package booth_mult_r4_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {ZERO = 2'd0, PM1 = 2'd1, PM2 = 2'd2} dsel_e;
  typedef struct packed {
    logic  neg;
    dsel_e sel;
  } digit_t;
  function automatic int n_iter(input int w);
    return w / 2 + 1;
  endfunction
  function automatic digit_t recode(input logic [2:0] t);
    digit_t d;
    d.sel = (t == 3'b000 || t == 3'b111) ? ZERO : (t == 3'b011 || t == 3'b100) ? PM2 : PM1;
    d.neg = t[2] & ~&t[1:0];
    return d;
  endfunction
endpackage

// File: rtl/booth_r4_step.sv
// booth_r4_step: one radix-4 Booth iteration, add the recoded multiple of M to A then shift right by two
module booth_r4_step
  import booth_mult_r4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   trip_i,
  input  logic [W+3:0] a_i,
  input  logic [W+1:0] m_i,
  output logic [W+3:0] a_o,
  output logic [1:0]   q_o
);
  digit_t d;
  logic [W+3:0] m_x, km, sum;
  assign d   = recode(trip_i);
  assign m_x = {{2{m_i[W+1]}}, m_i};
  assign km  = d.sel == ZERO ? '0 : d.sel == PM2 ? m_x << 1 : m_x;
  assign sum = a_i + (d.neg ? ~km : km) + {{(W+3){1'b0}}, d.neg};
  // The two bits falling out of A become the new top bits of Q
  assign a_o = {{2{sum[W+3]}}, sum[W+3:2]};
  assign q_o = sum[1:0];
endmodule

// File: rtl/booth_mult_r4.sv
// booth_mult_r4: sequential radix-4 Booth multiplier, signed/unsigned per operation, valid/ready on both sides
module booth_mult_r4
  import booth_mult_r4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           in_ready,
  input  logic [W-1:0]   mc,
  input  logic [W-1:0]   mp,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);
  localparam int N  = n_iter(W);
  localparam int CW = $clog2(N + 1);
  state_e         state_q, state_d;
  logic [W+3:0]   a_q, a_d, a_s;
  logic [W+1:0]   q_q, q_d, m_q, m_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [1:0]     q_s;
  booth_r4_step #(.W(W)) u_step (
    .trip_i({q_q[1:0], q1_q}),
    .a_i   (a_q),
    .m_i   (m_q),
    .a_o   (a_s),
    .q_o   (q_s)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_d     = '0;
      q_d     = {{2{sgn & mp[W-1]}}, mp};
      q1_d    = 1'b0;
      m_d     = {{2{sgn & mc[W-1]}}, mc};
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_s;
      q_d   = {q_s, q_q[W+1:2]};
      q1_d  = q_q[1];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        state_d = DONE;
        prod_d  = {a_s[W-3:0], q_s, q_q[W+1:2]};
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign out_valid = state_q == DONE;
  assign prod      = prod_q;
endmodule

// File: tb/tb_booth_mult_r4.sv
// tb_booth_mult_r4: directed vector table and backpressure/reset sequences at W=8, random regression at W=16
module tb_booth_mult_r4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start8 = 1'b0, sgn8 = 1'b0, ordy8 = 1'b1, ir8, ov8, busy8;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic [15:0] prod8;
  logic        start16 = 1'b0, sgn16 = 1'b0, ordy16 = 1'b0, ir16, ov16, busy16;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic [31:0] prod16;
  int checks = 0, failures = 0;

  typedef struct {
    logic        s;
    logic [7:0]  a, b;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  booth_mult_r4 #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(ir8), .mc(mc8), .mp(mp8), .sgn(sgn8),
    .out_valid(ov8), .out_ready(ordy8), .prod(prod8), .busy(busy8)
  );
  booth_mult_r4 #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_ready(ir16), .mc(mc16), .mp(mp16), .sgn(sgn16),
    .out_valid(ov16), .out_ready(ordy16), .prod(prod16), .busy(busy16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen (or the bound expires)
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bcnt, output logic ir0);
    start8 = 1'b1; sgn8 = s; mc8 = a; mp8 = b;
    @(negedge clk);
    start8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom); sgn8 = 1'($urandom);
    lat = 0; bcnt = int'(busy8); ir0 = ir8;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy8);
    end
  endtask

  function automatic logic [31:0] ref16(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, pe;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    pe = pa * pb;
    return pe[31:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bc;
    logic ir0;
    logic [15:0] hold;
    vt[0] = '{1'b1, 8'd30,  8'd13,  16'd390};
    vt[1] = '{1'b1, 8'h80,  8'h80,  16'd16384};
    vt[2] = '{1'b1, 8'hFF,  8'h7F,  16'hFF81};
    vt[3] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    vt[4] = '{1'b0, 8'd255, 8'd255, 16'd65025};
    vt[5] = '{1'b0, 8'd128, 8'd2,   16'd256};
    vt[6] = '{1'b1, 8'hFF,  8'hFF,  16'd1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", ir8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_out_valid", ov8, 0);
    chk("rst_prod", prod8, 0);
    @(negedge clk);
    op8(1'b1, 8'd30, 8'd13, lat, bc, ir0);
    chk("first_in_ready_drop", ir0, 0);
    chk("first_busy_cycles", bc, 5);
    chk("first_latency", lat, 5);
    chk("first_prod", prod8, 390);
    @(negedge clk);
    chk("first_in_ready_back", ir8, 1);
    chk("first_out_valid_fall", ov8, 0);
    for (int i = 0; i < 7; i++) begin
      op8(vt[i].s, vt[i].a, vt[i].b, lat, bc, ir0);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_prod", i), prod8, vt[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_complete", i), {ir8, ov8}, 2'b10);
    end
    ordy8 = 1'b0;
    op8(1'b1, 8'hF9, 8'd9, lat, bc, ir0);
    hold = prod8;
    chk("bp_prod", prod8, 16'hFFC1);
    for (int i = 0; i < 6; i++) begin
      start8 = 1'b1; mc8 = 8'($urandom); mp8 = 8'($urandom); sgn8 = ~sgn8;
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {ov8, busy8, ir8, prod8}, {3'b100, hold});
    end
    start8 = 1'b0;
    ordy8 = 1'b1;
    @(negedge clk);
    chk("bp_release", {ov8, ir8}, 2'b01);
    @(negedge clk);
    chk("bp_no_second_op", {busy8, ov8}, 2'b00);
    start8 = 1'b1; sgn8 = 1'b1; mc8 = 8'd100; mp8 = 8'd100;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {ir8, busy8, ov8}, 3'b100);
    chk("abort_prod", prod8, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_valid", ov8, 0);
    op8(1'b1, 8'd7, 8'hFD, lat, bc, ir0);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_prod", prod8, 16'hFFEB);
    @(negedge clk);
    for (int k = 0; k < 2000; k++) begin
      logic        s;
      logic [15:0] a, b;
      logic [31:0] e;
      int          g;
      s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (k % 8 == 0) a = 16'h8000;
      if (k % 8 == 1) b = 16'hFFFF;
      e = ref16(s, a, b);
      start16 = 1'b1; sgn16 = s; mc16 = a; mp16 = b;
      ordy16 = 1'($urandom);
      @(negedge clk);
      start16 = 1'b0; mc16 = 16'($urandom); mp16 = 16'($urandom); sgn16 = 1'($urandom);
      lat = 0;
      while (!ov16 && lat < 40) begin
        ordy16 = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      chk("w16_latency", lat, 9);
      chk("w16_prod", prod16, e);
      g = 0;
      do begin
        ordy16 = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        g++;
      end while (ov16 && g < 100);
      chk("w16_complete", {ov16, ir16}, 2'b01);
      chk("w16_prod_retained", prod16, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
